// File: rtl/accum_scheduler.sv
// -----------------------------------------------------------------------------
// accum_scheduler
//
// Sequences one block of samples into an external free-running accumulator.
// The accumulator registers acc_out <= acc_reset ? 0 : acc_out + acc_in on every
// clock. This block chooses what it adds and when it clears. When len samples
// have been accepted, the block presents the registered sum on result.
//
// Ports
//   clk           : clock, rising edge
//   reset         : asynchronous, active-low reset
//   start, len    : request a block of len samples (sampled only in IDLE)
//   abort         : abandon the current block (ACCUM or DONE)
//   in_data/in_valid/in_ready : sample stream from the upstream source
//   acc_reset     : synchronous clear to the accumulator (active high)
//   acc_in        : addend to the accumulator
//   acc_out       : registered accumulator value
//   result/result_valid/result_ready : completed block sum to downstream
//   busy          : high in ACCUM or DONE
//   count         : samples accepted in the current block
//   state_dbg     : current FSM state (IDLE=0, ACCUM=1, DONE=2)
//
// Handshake rule (both streams): a transfer happens on a rising edge where
// valid and ready are both high. A producer holding valid keeps its data stable
// until that edge. result stays stable while result_valid is high and
// result_ready is low.
// -----------------------------------------------------------------------------
module accum_scheduler #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             acc_reset,
    output logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] count_inc;
    logic             accept;

    assign state_dbg = state;
    assign count_inc = count + CNT_W'(1);
    // in_ready is high for the whole of ACCUM, so the valid input alone decides acceptance.
    assign accept    = (state == ACCUM) && in_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            len_q <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len;
                        count <= '0;
                        // A zero-length block has nothing to add. The accumulator
                        // was cleared throughout IDLE, so DONE presents 0.
                        state <= (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (accept) begin
                        count <= count_inc;
                        // The final sample goes into the accumulator on this same
                        // edge, so acc_out holds the full sum from the first DONE cycle.
                        if (count_inc == len_q) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (abort || result_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the state only, so an asynchronous reset forces the idle
    // values at once, without waiting for a clock edge.
    always_comb begin
        acc_reset    = 1'b0;
        acc_in       = '0;
        in_ready     = 1'b0;
        result       = '0;
        result_valid = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
                acc_reset = 1'b1;
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // Add zero on idle cycles so that a gap never repeats a sample.
                if (in_valid) begin
                    acc_in = in_data;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                busy         = 1'b1;
                result       = acc_out;
            end
            default: begin
                acc_reset = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_accum_scheduler.sv
module tb_accum_scheduler;
    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    // ---------------- clock / reset / signals ----------------
    logic             clk          = 1'b0;
    logic             reset        = 1'b0;
    logic             start        = 1'b0;
    logic [CNT_W-1:0] len          = '0;
    logic             abort        = 1'b0;
    logic [WIDTH-1:0] in_data      = '0;
    logic             in_valid     = 1'b0;
    logic             result_ready = 1'b0;
    logic             in_ready;
    logic             acc_reset;
    logic [WIDTH-1:0] acc_in;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic [1:0]       state_dbg;
    logic [WIDTH-1:0] acc_out = '0;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] stim_q[$];
    logic [WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    // External accumulator: registered, clears synchronously, adds every clock.
    always @(posedge clk) begin
        acc_out <= acc_reset ? '0 : acc_out + acc_in;
    end

    accum_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .acc_reset(acc_reset), .acc_in(acc_in), .acc_out(acc_out),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .busy(busy), .count(count), .state_dbg(state_dbg)
    );

    // ---------------- reference model ----------------
    // A block's result is the sum of its samples modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] model_sum();
        logic [WIDTH-1:0] s = '0;
        foreach (stim_q[i]) s = s + stim_q[i];
        return s;
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks are entered and left just after a falling edge.
    task automatic begin_block(input logic [CNT_W-1:0] blen);
        start = 1'b1;
        len   = blen;
        @(negedge clk);
        start = 1'b0;
        len   = CNT_W'($urandom);
    endtask

    // Presents every sample in stim_q. Before each sample it inserts gap_min..gap_max
    // idle cycles. It counts cycles where acc_in or in_ready was wrong.
    task automatic feed(input int gap_min, input int gap_max, output int bad);
        int gaps;
        bad = 0;
        foreach (stim_q[i]) begin
            gaps = $urandom_range(gap_max, gap_min);
            repeat (gaps) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                #1;
                if (acc_in !== '0 || in_ready !== 1'b1) bad++;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = stim_q[i];
            #1;
            if (acc_in !== stim_q[i] || in_ready !== 1'b1) bad++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        #3;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (acc_reset !== 1'b1) begin errors++; $display("FAIL reset_acc_reset: got %b expected 1", acc_reset); end
        checks++; if (acc_in !== '0) begin errors++; $display("FAIL reset_acc_in: got %h expected 0", acc_in); end
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL reset_busy_valid: got %b%b expected 00", busy, result_valid); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (result !== '0 || acc_reset !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_outputs: got result=%h acc_reset=%b busy=%b expected 0/1/0", result, acc_reset, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        int bad;
        begin_block(3);
        stim_q = '{32'h1, 32'h2, 32'hF0};
        exp_q.push_back(32'h0000_00F3);
        feed(0, 0, bad);
        #1;
        checks++; if (bad !== 0) begin errors++; $display("FAIL basic_feed: got %0d bad cycles expected 0", bad); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", result_valid); end
        checks++; if (result !== exp_q[0]) begin errors++; $display("FAIL basic_result: got %h expected %h", result, exp_q[0]); end
        checks++; if (count !== CNT_W'(3)) begin errors++; $display("FAIL basic_count: got %0d expected 3", count); end
        checks++; if (in_ready !== 1'b0 || acc_in !== '0 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_done_outputs: got in_ready=%b acc_in=%h busy=%b expected 0/0/1", in_ready, acc_in, busy);
        end
        void'(exp_q.pop_front());
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b0 || result !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_consume: got valid=%b result=%h busy=%b expected 0/0/0", result_valid, result, busy);
        end
    endtask

    task automatic test_gaps();
        int bad;
        @(negedge clk);
        begin_block(2);
        stim_q = '{32'h5, 32'h7};
        feed(3, 3, bad);
        #1;
        checks++; if (bad !== 0) begin errors++; $display("FAIL gaps_acc_in: got %0d bad cycles expected 0", bad); end
        checks++; if (result_valid !== 1'b1 || result !== 32'h0000_000C) begin
            errors++; $display("FAIL gaps_result: got valid=%b result=%h expected 1/0000000c", result_valid, result);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int bad;
        begin_block(2);
        stim_q = '{32'hFFFF_FFFF, 32'h2};
        feed(0, 1, bad);
        #1;
        checks++; if (result_valid !== 1'b1 || result !== 32'h0000_0001) begin
            errors++; $display("FAIL wrap_result: got valid=%b result=%h expected 1/00000001", result_valid, result);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_len_zero();
        begin_block(0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (result_valid !== 1'b1 || result !== '0 || busy !== 1'b1) begin
                errors++; $display("FAIL len0_hold%0d: got valid=%b result=%h busy=%b expected 1/0/1", i, result_valid, result, busy);
            end
            @(negedge clk);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL len0_consume: got %b expected 0", result_valid); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int bad;
        begin_block(4);
        stim_q = '{32'h1234};
        feed(0, 0, bad);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || acc_reset !== 1'b1) begin
            errors++; $display("FAIL abort_idle: got busy=%b valid=%b acc_reset=%b expected 0/0/1", busy, result_valid, acc_reset);
        end
        @(negedge clk);
        begin_block(1);
        stim_q = '{32'hABCD_0000};
        feed(0, 0, bad);
        #1;
        checks++; if (result_valid !== 1'b1 || result !== 32'hABCD_0000) begin
            errors++; $display("FAIL abort_next_block: got valid=%b result=%h expected 1/abcd0000", result_valid, result);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        // abort beats completion of the last sample
        begin_block(1);
        in_valid = 1'b1;
        in_data  = 32'h99;
        abort    = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_priority_accum: got valid=%b busy=%b expected 0/0", result_valid, busy);
        end
        @(negedge clk);
        // abort in DONE leaves without another result cycle
        begin_block(0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_done: got valid=%b busy=%b expected 0/0", result_valid, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int bad;
        begin_block(4);
        stim_q = '{32'h11};
        feed(0, 0, bad);
        in_valid = 1'b1;
        in_data  = 32'h55;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || acc_reset !== 1'b1 || acc_in !== '0) begin
            errors++; $display("FAIL async_reset_outputs: got in_ready=%b acc_reset=%b acc_in=%h expected 0/1/0", in_ready, acc_reset, acc_in);
        end
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || count !== '0) begin
            errors++; $display("FAIL async_reset_state: got busy=%b valid=%b count=%0d expected 0/0/0", busy, result_valid, count);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        begin_block(1);
        stim_q = '{32'h77};
        feed(0, 0, bad);
        #1;
        checks++; if (result_valid !== 1'b1 || result !== 32'h77 || count !== CNT_W'(1)) begin
            errors++; $display("FAIL after_reset_block: got valid=%b result=%h count=%0d expected 1/77/1", result_valid, result, count);
        end
        // start while DONE is ignored
        start = 1'b1;
        len   = 5;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b1 || result !== 32'h77 || in_ready !== 1'b0 || count !== CNT_W'(1)) begin
            errors++; $display("FAIL start_in_done: got valid=%b result=%h in_ready=%b count=%0d expected 1/77/0/1", result_valid, result, in_ready, count);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL start_in_done_idle: got busy=%b in_ready=%b expected 0/0", busy, in_ready);
        end
    endtask

    task automatic test_random(input int blocks, input int gap_max, input int ready_max);
        int bad;
        int n;
        int dly;
        logic [WIDTH-1:0] exp;
        for (int b = 0; b < blocks; b++) begin
            n = $urandom_range(8, 1);
            stim_q.delete();
            for (int i = 0; i < n; i++) stim_q.push_back($urandom);
            exp_q.push_back(model_sum());
            begin_block(CNT_W'(n));
            feed(0, gap_max, bad);
            exp = exp_q.pop_front();
            dly = $urandom_range(ready_max, 0);
            for (int d = 0; d <= dly; d++) begin
                #1;
                checks++; if (result_valid !== 1'b1 || result !== exp || count !== CNT_W'(n) || bad !== 0) begin
                    errors++; $display("FAIL random_block%0d: got valid=%b result=%h count=%0d bad=%0d expected 1/%h/%0d/0",
                                       b, result_valid, result, count, bad, exp, n);
                end
                if (d == dly) result_ready = 1'b1;
                @(negedge clk);
            end
            result_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_wrap();
        test_len_zero();
        test_abort();
        test_async_reset();
        test_random(8, 2, 3);
        test_random(4, 0, 0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
